// File: rtl/mul4_share_ctrl.sv
// Shares one 4x4 array multiplier between two requesters, product returned with requester id.
// Latency: accept to rsp_valid is MUL_LAT cycles; one product per MUL_LAT+2 cycles at best.
// Backpressure: rsp_ready low holds RESP and keeps both req ready low. Round-robin tie-break when MUL4_SHARE_RR_EN is defined.

module mul4_array (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [7:0] p
);
    logic [7:0] acc;

    // One shifted partial-product row per bit of b, summed row by row.
    always_comb begin
        acc = {7'b0, cin};
        for (int i = 0; i < 4; i++) begin
            acc = acc + ({4'b0, a & {4{b[i]}}} << i);
        end
    end

    assign p = acc;
endmodule

module mul4_share_ctrl #(
    parameter int MUL_LAT = 1    // settle cycles, 1..4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_id;
    logic [7:0] prod;
    logic       grant1;
    logic       accept;

`ifdef MUL4_SHARE_RR_EN
    logic ptr;

    // Tie goes to the requester that was not accepted last.
    always_comb grant1 = req1_valid & (~req0_valid | ~ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b1;
        end else if (accept) begin
            ptr <= grant1;
        end
    end
`else
    always_comb grant1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = (state == IDLE) & req0_valid & ~grant1;
    assign req1_ready = (state == IDLE) & req1_valid & grant1;
    assign accept     = req0_ready | req1_ready;

    mul4_array u_mul (
        .a   (op_a),
        .b   (op_b),
        .cin (1'b0),
        .p   (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            op_a      <= 4'd0;
            op_b      <= 4'd0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_p     <= 8'd0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= grant1 ? req1_a : req0_a;
                        op_b  <= grant1 ? req1_b : req0_b;
                        op_id <= grant1;
                        cnt   <= 2'(MUL_LAT - 1);
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (cnt == 2'd0) begin
                        rsp_p     <= prod;
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul4_share_ctrl.sv
// Directed bench for mul4_share_ctrl: MUL_LAT=1 instance for arbitration/backpressure/reset, MUL_LAT=3 instance for latency.
module tb_mul4_share_ctrl;
    typedef struct packed { logic id; logic [7:0] p; } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [3:0] r0_a, r0_b, r1_a, r1_b;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_p;
    logic       s3_r0_valid, s3_r0_ready, s3_r1_valid, s3_r1_ready;
    logic [3:0] s3_r0_a, s3_r0_b, s3_r1_a, s3_r1_b;
    logic       s3_rsp_valid, s3_rsp_ready, s3_rsp_id, s3_busy;
    logic [7:0] s3_rsp_p;

    exp_t exp_q[$];
    exp_t exp3_q[$];
    exp_t got, got3;
    int   passed = 0, failed = 0, total = 0, unexp = 0, n;

`ifdef MUL4_SHARE_RR_EN
    localparam logic [3:0] TIE_IDS = 4'b1010;
`else
    localparam logic [3:0] TIE_IDS = 4'b1000;
`endif
    logic [3:0] tie_ids;

    always #5 clk = ~clk;

    mul4_share_ctrl #(.MUL_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_a(r0_a), .req0_b(r0_b),
        .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_a(r1_a), .req1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .busy(busy)
    );

    mul4_share_ctrl #(.MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(s3_r0_valid), .req0_ready(s3_r0_ready), .req0_a(s3_r0_a), .req0_b(s3_r0_b),
        .req1_valid(s3_r1_valid), .req1_ready(s3_r1_ready), .req1_a(s3_r1_a), .req1_b(s3_r1_b),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_id(s3_rsp_id), .rsp_p(s3_rsp_p),
        .busy(s3_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic id, input logic [7:0] p, input bit to3);
        exp_t e;
        e.id = id;
        e.p  = p;
        if (to3) exp3_q.push_back(e);
        else     exp_q.push_back(e);
    endtask

    task automatic wait_rdy(input bit which, input string tag);
        int k = 0;
        #1;
        while (!(which ? r1_ready : r0_ready) && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 8'(which ? r1_ready : r0_ready), 8'd1);
    endtask

    // Response scoreboard: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) unexp++;
            else begin
                got = exp_q.pop_front();
                chk("rsp_id", 8'(rsp_id), 8'(got.id));
                chk("rsp_p", rsp_p, got.p);
            end
        end
        if (!rst && s3_rsp_valid && s3_rsp_ready) begin
            if (exp3_q.size() == 0) unexp++;
            else begin
                got3 = exp3_q.pop_front();
                chk("lat3_rsp_id", 8'(s3_rsp_id), 8'(got3.id));
                chk("lat3_rsp_p", s3_rsp_p, got3.p);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        tie_ids = TIE_IDS;
        r0_valid = 0; r0_a = 0; r0_b = 0; r1_valid = 0; r1_a = 0; r1_b = 0; rsp_ready = 1;
        s3_r0_valid = 0; s3_r0_a = 0; s3_r0_b = 0; s3_r1_valid = 0; s3_r1_a = 0; s3_r1_b = 0;
        s3_rsp_ready = 1;

        // Reset state
        tick();
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_rsp_p", rsp_p, 8'd0);
        chk("rst_rsp_id", 8'(rsp_id), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        tick();
        rst = 0;
        tick();

        // Single request, MUL_LAT=1
        r0_valid = 1; r0_a = 3; r0_b = 5; push(1'b0, 8'd15, 1'b0);
        #1;
        chk("single_req0_ready", 8'(r0_ready), 8'd1);
        chk("single_req1_ready", 8'(r1_ready), 8'd0);
        tick();
        r0_valid = 0;
        chk("single_busy_calc", 8'(busy), 8'd1);
        chk("single_valid_early", 8'(rsp_valid), 8'd0);
        tick();
        chk("single_rsp_valid", 8'(rsp_valid), 8'd1);
        chk("single_rsp_p", rsp_p, 8'd15);
        chk("single_busy_resp", 8'(busy), 8'd1);
        tick();
        chk("single_busy_idle", 8'(busy), 8'd0);
        chk("single_valid_clear", 8'(rsp_valid), 8'd0);

        // Reset mid-operation: req0 accepted, rst asserted during CALC
        r0_valid = 1; r0_a = 6; r0_b = 7;
        wait_rdy(1'b0, "midrst_accept");
        tick();
        r0_valid = 0;
        #1 rst = 1;
        #1;
        chk("midrst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_rsp_p", rsp_p, 8'd0);
        tick();
        rst = 0;
        repeat (3) tick();
        chk("midrst_no_rsp", 8'(rsp_valid), 8'd0);
        chk("midrst_idle", 8'(busy), 8'd0);

        // Tie: both requesters held valid
        r0_valid = 1; r0_a = 15; r0_b = 15; r1_valid = 1; r1_a = 2; r1_b = 7;
        for (int k = 0; k < 4; k++) push(tie_ids[k], tie_ids[k] ? 8'd14 : 8'd225, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(r0_ready || r1_ready) && n < 20) begin
                tick();
                n++;
            end
            chk("tie_any_ready", 8'(r0_ready | r1_ready), 8'd1);
            chk("tie_grant_id", 8'(r1_ready), 8'(tie_ids[k]));
            chk("tie_one_hot", 8'(r0_ready & r1_ready), 8'd0);
            tick();
`ifndef MUL4_SHARE_RR_EN
            if (k == 2) r0_valid = 0;
`endif
        end
        r0_valid = 0; r1_valid = 0;
        repeat (4) tick();

        // Back-pressure with req1 pending
        rsp_ready = 0;
        r0_valid = 1; r0_a = 4; r0_b = 5; push(1'b0, 8'd20, 1'b0);
        wait_rdy(1'b0, "bp_req0_accept");
        tick();
        r0_valid = 0;
        r1_valid = 1; r1_a = 9; r1_b = 9; push(1'b1, 8'd81, 1'b0);
        tick();
        chk("bp_rsp_valid", 8'(rsp_valid), 8'd1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_req1_ready_low", 8'(r1_ready), 8'd0);
            chk("bp_rsp_p_hold", rsp_p, 8'd20);
            chk("bp_rsp_id_hold", 8'(rsp_id), 8'd0);
            chk("bp_rsp_valid_hold", 8'(rsp_valid), 8'd1);
            tick();
        end
        rsp_ready = 1;
        tick();
        chk("bp_back_idle", 8'(busy), 8'd0);
        #1;
        chk("bp_req1_ready", 8'(r1_ready), 8'd1);
        tick();
        r1_valid = 0;
        chk("bp_req1_busy", 8'(busy), 8'd1);
        repeat (3) tick();

        // MUL_LAT=3 latency
        s3_r1_valid = 1; s3_r1_a = 12; s3_r1_b = 10; push(1'b1, 8'd120, 1'b1);
        #1;
        chk("lat3_req1_ready", 8'(s3_r1_ready), 8'd1);
        tick();
        s3_r1_valid = 0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("lat3_rsp_valid_edge", 8'(s3_rsp_valid), 8'(e == 3));
        end
        repeat (3) tick();

        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        chk("lat3_queue_drained", 8'(exp3_q.size()), 8'd0);
        chk("unexpected_rsp", 8'(unexp), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
